stoch_to_bin: RTL and testbench

Stochastic-to-binary converter that sits directly downstream of the cascaded MUX adder. It counts the ones in the adder's output bitstream over a fixed window of enabled cycles. It rescales the count by the adder fan-in and presents the result as a binary word through a valid/ready handshake. This is the read-out point where neuron sums leave the stochastic domain.

---
 rtl/stoch_pkg.sv | 25 ++
 rtl/sc_window_ctr.sv | 25 ++
 rtl/stoch_to_bin.sv | 116 +++++++++++
 tb/tb_stoch_to_bin.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic read-out blocks: FSM state encoding
// and the saturating clip used when a scaled count is squeezed into a word.
package stoch_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Largest value representable in w bits (w capped at 32).
  function automatic logic [31:0] sat_max(input int w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  // Clip p to the w-bit unsigned range.
  function automatic logic [31:0] sat_clip(input logic [31:0] p, input int w);
    return (p > sat_max(w)) ? sat_max(w) : p;
  endfunction

  // High when p does not fit in w bits.
  function automatic logic sat_flag(input logic [31:0] p, input int w);
    return p > sat_max(w);
  endfunction

endpackage

// File: rtl/sc_window_ctr.sv
// Enabled window counter: counts EN-qualified samples modulo 2^L and flags
// the sample that completes the window.
module sc_window_ctr #(
  parameter int L = 8
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  logic [L-1:0] r_cnt;

  // Synchronous clear wins over counting; wraps to 0 after the last sample.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + L'(1);
    end
  end

  assign o_last = i_en && (r_cnt == {L{1'b1}});

endmodule

// File: rtl/stoch_to_bin.sv
// Stochastic-to-binary converter: counts ones of the MUX-adder bitstream over
// 2^L enabled cycles, rescales by the adder fan-in, saturates to OUT_W bits
// and hands the word off through a valid/ready handshake.
module stoch_to_bin
  import stoch_pkg::*;
#(
  parameter int L     = 8,
  parameter int OUT_W = 8,
  parameter int SCALE = 1,
  parameter int AUTO  = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             IN,
  input  logic             START,
  input  logic             READY,
  output logic             BUSY,
  output logic             VALID,
  output logic [OUT_W-1:0] OUT,
  output logic             SAT
);

  // Full-width product: count (L+1 bits) times the rescale factor.
  localparam int PW = L + 1 + $clog2(SCALE + 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [L:0]       r_ones;
  logic [L:0]       w_total;
  logic [PW-1:0]    w_p;
  logic             w_smp;
  logic             w_last;
  logic             w_accept;
  logic             w_start_win;
  logic             w_clr;
  logic [OUT_W-1:0] r_out;
  logic             r_sat;

  // Samples are taken only while accumulating; IN/EN are ignored elsewhere.
  assign w_smp       = EN && (r_state == ST_ACC);
  assign w_accept    = (r_state == ST_DONE) && READY;
  assign w_start_win = ((r_state == ST_IDLE) && START) ||
                       (w_accept && ((AUTO != 0) || START));
  assign w_clr       = RST || w_start_win;

  // The final sample is folded in combinationally so the result registers
  // on the same edge that takes it.
  assign w_total = r_ones + {{L{1'b0}}, IN};
  assign w_p     = PW'(w_total) * PW'(SCALE);

  sc_window_ctr #(
    .L(L)
  ) u_win (
    .i_clk (CLK),
    .i_clr (w_clr),
    .i_en  (w_smp),
    .o_last(w_last)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: START is only honoured in IDLE or on an accept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (START)  w_next = ST_ACC;
      ST_ACC:  if (w_last) w_next = ST_DONE;
      ST_DONE: if (READY)  w_next = ((AUTO != 0) || START) ? ST_ACC : ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  // Status outputs decode straight from the state register, so READY has
  // no combinational path to VALID.
  always_comb begin
    BUSY  = 1'b0;
    VALID = 1'b0;
    case (r_state)
      ST_ACC:  BUSY  = 1'b1;
      ST_DONE: VALID = 1'b1;
      default: ;
    endcase
  end

  // Ones counter: cleared at each window start, advanced on enabled samples.
  always_ff @(posedge CLK) begin
    if (RST || w_start_win) begin
      r_ones <= '0;
    end else if (w_smp) begin
      r_ones <= w_total;
    end
  end

  // Result registers: loaded once per window and held through the handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out <= '0;
      r_sat <= 1'b0;
    end else if (w_last) begin
      r_out <= OUT_W'(sat_clip(32'(w_p), OUT_W));
      r_sat <= sat_flag(32'(w_p), OUT_W);
    end
  end

  assign OUT = r_out;
  assign SAT = r_sat;

endmodule

// File: tb/tb_stoch_to_bin.sv
// Bench for stoch_to_bin: three L=4 instances with different width/scale
// share one stimulus stream; a count-and-clip model predicts every window.
module tb_stoch_to_bin;

  logic clk = 1'b0;
  logic rst, en, s_in, start, ready;

  logic       busy_a, valid_a, sat_a;
  logic [3:0] out_a;
  logic       busy_b, valid_b, sat_b;
  logic [5:0] out_b;
  logic       busy_c, valid_c, sat_c;
  logic [5:0] out_c;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  stoch_to_bin #(.L(4), .OUT_W(4), .SCALE(1), .AUTO(0)) dut_a (
    .CLK(clk), .RST(rst), .EN(en), .IN(s_in), .START(start), .READY(ready),
    .BUSY(busy_a), .VALID(valid_a), .OUT(out_a), .SAT(sat_a));

  stoch_to_bin #(.L(4), .OUT_W(6), .SCALE(3), .AUTO(0)) dut_b (
    .CLK(clk), .RST(rst), .EN(en), .IN(s_in), .START(start), .READY(ready),
    .BUSY(busy_b), .VALID(valid_b), .OUT(out_b), .SAT(sat_b));

  stoch_to_bin #(.L(4), .OUT_W(6), .SCALE(4), .AUTO(0)) dut_c (
    .CLK(clk), .RST(rst), .EN(en), .IN(s_in), .START(start), .READY(ready),
    .BUSY(busy_c), .VALID(valid_c), .OUT(out_c), .SAT(sat_c));

  function automatic int exp_out(input int n, input int s, input int w);
    int p, mx;
    p  = n * s;
    mx = (1 << w) - 1;
    return (p > mx) ? mx : p;
  endfunction

  function automatic int exp_sat(input int n, input int s, input int w);
    return ((n * s) > ((1 << w) - 1)) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int ones);
    check({tag, "_out_a"}, int'(out_a), exp_out(ones, 1, 4));
    check({tag, "_sat_a"}, int'(sat_a), exp_sat(ones, 1, 4));
    check({tag, "_out_b"}, int'(out_b), exp_out(ones, 3, 6));
    check({tag, "_sat_b"}, int'(sat_b), exp_sat(ones, 3, 6));
    check({tag, "_out_c"}, int'(out_c), exp_out(ones, 4, 6));
    check({tag, "_sat_c"}, int'(sat_c), exp_sat(ones, 4, 6));
  endtask

  task automatic start_edge(input string tag);
    start = 1'b1; ready = 1'b0;
    en = 1'($urandom); s_in = 1'($urandom);
    step();
    start = 1'b0;
    check({tag, "_start_busy"}, int'(busy_a), 1);
    check({tag, "_start_valid"}, int'(valid_a), 0);
  endtask

  // Drives one window after the START edge. mode: 0 alternating, 1 all ones,
  // 2 all zeros, 3 EN toggling with IN only on EN=0, 4 random incl. stray
  // START/READY, 5 first k samples one. exp_lat=0 skips the latency check.
  task automatic collect(input string tag, input int mode, input int k,
                         input int exp_lat, output int ones);
    int  edges, nen, bad_busy, bad_valid;
    bit  e, b;
    edges = 1; nen = 0; bad_busy = 0; bad_valid = 0; ones = 0;
    while (nen < 16 && edges < 300) begin
      e = 1'b1; b = 1'b0;
      case (mode)
        0: b = (nen % 2 == 0);
        1: b = 1'b1;
        2: b = 1'b0;
        3: begin e = (edges % 2 == 0); b = !e; end
        4: begin
          e = (($urandom % 4) != 0); b = 1'($urandom);
          start = 1'($urandom); ready = 1'($urandom);
        end
        default: b = (nen < k);
      endcase
      en = e; s_in = b;
      step();
      edges++;
      if (e) begin nen++; ones += int'(b); end
      if (nen < 16) begin
        if (!(busy_a && busy_b && busy_c)) bad_busy++;
        if (valid_a || valid_b || valid_c) bad_valid++;
      end
    end
    start = 1'b0; ready = 1'b0;
    check({tag, "_busy_in_window"}, bad_busy, 0);
    check({tag, "_early_valid"}, bad_valid, 0);
    check({tag, "_valid_a"}, int'(valid_a), 1);
    check({tag, "_valid_bc"}, int'(valid_b && valid_c), 1);
    check({tag, "_busy_done"}, int'(busy_a), 0);
    if (exp_lat > 0) check({tag, "_latency"}, edges, exp_lat);
    check_outs(tag, ones);
  endtask

  task automatic accept(input string tag);
    ready = 1'b1; en = 1'($urandom); s_in = 1'($urandom);
    step();
    ready = 1'b0;
    check({tag, "_acc_valid"}, int'(valid_a), 0);
    check({tag, "_acc_busy"}, int'(busy_a), 0);
  endtask

  initial begin
    int ones, bad, saved;
    rst = 1'b1; en = 1'b0; s_in = 1'b0; start = 1'b0; ready = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    check("rst_busy", int'(busy_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_out", int'(out_a), 0);
    check("rst_sat", int'(sat_c), 0);

    // Idle with activity on IN/EN and READY: nothing should move.
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      en = 1'($urandom); s_in = 1'($urandom); ready = 1'($urandom);
      step();
      if (busy_a || valid_a || out_a != 0) bad++;
    end
    ready = 1'b0;
    check("idle_quiet", bad, 0);

    start_edge("alt");   collect("alt", 0, 0, 17, ones);
    check("alt_out_8", int'(out_a), 8);
    accept("alt");
    start_edge("ones");  collect("ones", 1, 0, 17, ones);
    check("ones_sat_a", int'(sat_a), 1);
    accept("ones");
    start_edge("zeros"); collect("zeros", 2, 0, 17, ones);
    accept("zeros");
    start_edge("tog");   collect("tog", 3, 0, 33, ones);
    accept("tog");
    start_edge("k5");    collect("k5", 5, 5, 17, ones);
    check("k5_out_b_15", int'(out_b), 15);
    accept("k5");

    // Handshake: hold READY low with stray STARTs, then accept and restart.
    start_edge("hs");    collect("hs", 1, 0, 17, ones);
    saved = int'(out_b); bad = 0;
    for (int i = 0; i < 10; i++) begin
      ready = 1'b0; start = 1'(i % 2);
      en = 1'($urandom); s_in = 1'($urandom);
      step();
      if (!valid_a || busy_a || int'(out_b) != saved) bad++;
    end
    check("hs_hold", bad, 0);
    ready = 1'b1; start = 1'b1;
    step();
    ready = 1'b0; start = 1'b0;
    check("hs_restart_valid", int'(valid_a), 0);
    check("hs_restart_busy", int'(busy_a), 1);
    collect("hs2", 0, 0, 17, ones);
    accept("hs2");

    // Reset at window sample 7, then a clean window.
    start_edge("rmid");
    for (int i = 0; i < 7; i++) begin
      en = 1'b1; s_in = 1'b1; step();
    end
    rst = 1'b1; step(); rst = 1'b0;
    check("rmid_busy", int'(busy_a), 0);
    check("rmid_valid", int'(valid_a), 0);
    check("rmid_out", int'(out_a) + int'(out_b) + int'(out_c), 0);
    start_edge("fresh"); collect("fresh", 0, 0, 17, ones);
    accept("fresh");

    // Reset while a result is held.
    start_edge("rval");  collect("rval", 1, 0, 17, ones);
    rst = 1'b1; step(); rst = 1'b0;
    check("rval_valid", int'(valid_a), 0);
    check("rval_busy", int'(busy_a), 0);
    check("rval_out", int'(out_a) + int'(out_c), 0);
    check("rval_sat", int'(sat_a) + int'(sat_c), 0);

    // Randomized windows.
    for (int w = 0; w < 6; w++) begin
      start_edge("rnd");
      collect("rnd", 4, 0, 0, ones);
      accept("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
